// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: round-robin arbiter between the instruction-cache and
// data-cache back-ends in front of the single L2 front-end. It grants one
// transaction at a time. It also serialises L2 force-invalidate requests so
// that an invalidate strobe is only issued while no access is outstanding.
module l2_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // instruction master (read-only)
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  // data master
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  // L2 side
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ready,
  // invalidate control and status
  input  logic                inv_req,
  output logic                force_inv,
  output logic                idle
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;
  localparam logic [1:0] INV   = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       inv_pend;
  // 1 when the data master received the most recent grant, 0 for instruction
  logic       last_gnt_d;

  // Next-state selection: a pending invalidate beats new grants, ties alternate
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (inv_pend)
          state_nxt = INV;
        else if (i_valid && !d_valid)
          state_nxt = GNT_I;
        else if (d_valid && !i_valid)
          state_nxt = GNT_D;
        else if (i_valid && d_valid)
          state_nxt = last_gnt_d ? GNT_I : GNT_D;
      end
      GNT_I: if (s_ready) state_nxt = IDLE;
      GNT_D: if (s_ready) state_nxt = IDLE;
      INV:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, pending-invalidate flag and round-robin history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      inv_pend   <= 1'b0;
      last_gnt_d <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt == INV)
        inv_pend <= 1'b0;
      else if (inv_req)
        inv_pend <= 1'b1;
      if (state == GNT_I && s_ready)
        last_gnt_d <= 1'b0;
      else if (state == GNT_D && s_ready)
        last_gnt_d <= 1'b1;
    end
  end

  // Request mux toward L2 and completion routing back to the granted master
  always_comb begin
    s_valid   = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    force_inv = 1'b0;
    case (state)
      GNT_I: begin
        s_valid = 1'b1;
        s_addr  = i_addr;
        i_ready = s_ready;
      end
      GNT_D: begin
        s_valid = 1'b1;
        s_addr  = d_addr;
        s_wdata = d_wdata;
        s_wstrb = d_wstrb;
        d_ready = s_ready;
      end
      INV: force_inv = 1'b1;
      default: ;
    endcase
  end

  assign idle    = (state == IDLE) && !inv_pend;
  assign i_rdata = s_rdata;
  assign d_rdata = s_rdata;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter: directed self-checking bench for l2_req_arbiter.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_l2_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic        inv_req;
  logic        force_inv;
  logic        idle;

  int errors = 0;
  int checks = 0;

  l2_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .inv_req(inv_req), .force_inv(force_inv), .idle(idle)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Move to the next falling edge, where stimulus is applied
  task automatic applyStimulus();
    @(negedge clk);
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Directed sequence of scenarios
  initial begin
    rst = 1'b1; i_valid = 0; i_addr = 0; d_valid = 0; d_addr = 0;
    d_wdata = 0; d_wstrb = 0; s_rdata = 0; s_ready = 0; inv_req = 0;
    applyStimulus();
    applyStimulus();
    #1;
    checkOutput("reset_idle", idle, 1);
    checkOutput("reset_s_valid", s_valid, 0);
    checkOutput("reset_force_inv", force_inv, 0);
    checkOutput("reset_i_ready", i_ready, 0);
    checkOutput("reset_d_ready", d_ready, 0);
    checkOutput("reset_s_addr", s_addr, 0);

    // Tie from reset: expect I, D, I, D with one IDLE cycle between grants
    applyStimulus();
    rst = 0; i_valid = 1; i_addr = 32'h200; d_valid = 1; d_addr = 32'h300; d_wstrb = 0;
    for (int g = 0; g < 4; g++) begin
      applyStimulus();
      #1;
      checkOutput("tie_s_valid", s_valid, 1);
      checkOutput("tie_s_addr", s_addr, (g % 2 == 0) ? 32'h200 : 32'h300);
      s_ready = 1;
      #1;
      checkOutput("tie_i_ready", i_ready, (g % 2 == 0) ? 1 : 0);
      checkOutput("tie_d_ready", d_ready, (g % 2 == 0) ? 0 : 1);
      applyStimulus();
      s_ready = 0;
      if (g == 3) begin i_valid = 0; d_valid = 0; end
      #1;
      checkOutput("tie_gap_s_valid", s_valid, 0);
      checkOutput("tie_gap_idle", idle, 1);
    end

    // Single D write, L2 completes in the third grant cycle
    applyStimulus();
    d_valid = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    for (int c = 0; c < 2; c++) begin
      applyStimulus();
      #1;
      checkOutput("dw_s_valid", s_valid, 1);
      checkOutput("dw_s_addr", s_addr, 32'h100);
      checkOutput("dw_s_wdata", s_wdata, 32'hDEADBEEF);
      checkOutput("dw_s_wstrb", s_wstrb, 4'hF);
      checkOutput("dw_wait_d_ready", d_ready, 0);
      checkOutput("dw_idle", idle, 0);
    end
    applyStimulus();
    s_ready = 1; s_rdata = 32'hCAFEF00D;
    #1;
    checkOutput("dw_d_ready", d_ready, 1);
    checkOutput("dw_i_ready", i_ready, 0);
    checkOutput("dw_d_rdata", d_rdata, 32'hCAFEF00D);
    applyStimulus();
    s_ready = 0; d_valid = 0;
    #1;
    checkOutput("dw_after_d_ready", d_ready, 0);
    checkOutput("dw_after_s_valid", s_valid, 0);
    checkOutput("dw_after_s_addr", s_addr, 0);
    checkOutput("dw_after_idle", idle, 1);

    // Two invalidate pulses during GNT_D collapse into one strobe after completion
    d_valid = 1; d_addr = 32'h500; d_wdata = 0; d_wstrb = 0;
    applyStimulus();
    #1;
    checkOutput("inv_gnt_s_valid", s_valid, 1);
    inv_req = 1;
    applyStimulus();
    inv_req = 0;
    #1;
    checkOutput("inv_gnt_hold_s_valid", s_valid, 1);
    checkOutput("inv_gnt_force_inv", force_inv, 0);
    inv_req = 1;
    applyStimulus();
    inv_req = 0; s_ready = 1;
    #1;
    checkOutput("inv_gnt_d_ready", d_ready, 1);
    applyStimulus();
    s_ready = 0;
    #1;
    checkOutput("inv_idle1_force_inv", force_inv, 0);
    checkOutput("inv_idle1_s_valid", s_valid, 0);
    checkOutput("inv_idle1_idle", idle, 0);
    applyStimulus();
    s_ready = 1;
    #1;
    checkOutput("inv_strobe", force_inv, 1);
    checkOutput("inv_s_valid", s_valid, 0);
    checkOutput("inv_spurious_d_ready", d_ready, 0);
    checkOutput("inv_spurious_i_ready", i_ready, 0);
    applyStimulus();
    s_ready = 0;
    #1;
    checkOutput("inv_after_force_inv", force_inv, 0);
    checkOutput("inv_after_idle", idle, 1);
    applyStimulus();
    #1;
    checkOutput("inv_regrant_s_valid", s_valid, 1);
    checkOutput("inv_regrant_s_addr", s_addr, 32'h500);
    checkOutput("inv_regrant_force_inv", force_inv, 0);
    s_ready = 1;
    #1;
    checkOutput("inv_regrant_d_ready", d_ready, 1);
    applyStimulus();
    s_ready = 0; d_valid = 0;
    applyStimulus();
    #1;
    checkOutput("inv_single_pulse", force_inv, 0);

    // Invalidate from IDLE: strobe two cycles after the request edge
    inv_req = 1;
    applyStimulus();
    inv_req = 0;
    #1;
    checkOutput("invidle_pend_force_inv", force_inv, 0);
    checkOutput("invidle_pend_idle", idle, 0);
    applyStimulus();
    #1;
    checkOutput("invidle_strobe", force_inv, 1);
    applyStimulus();
    #1;
    checkOutput("invidle_done", force_inv, 0);
    checkOutput("invidle_done_idle", idle, 1);

    // Spurious s_ready in IDLE
    s_ready = 1;
    #1;
    checkOutput("spur_idle_i_ready", i_ready, 0);
    checkOutput("spur_idle_d_ready", d_ready, 0);
    applyStimulus();
    s_ready = 0;
    #1;
    checkOutput("spur_idle_state", idle, 1);
    checkOutput("spur_idle_s_valid", s_valid, 0);

    // I read-only: data-side write fields must not leak through
    i_valid = 1; i_addr = 32'h40; d_wdata = 32'hFFFF0000; d_wstrb = 4'hA;
    applyStimulus();
    #1;
    checkOutput("ird_s_valid", s_valid, 1);
    checkOutput("ird_s_addr", s_addr, 32'h40);
    checkOutput("ird_s_wstrb", s_wstrb, 0);
    checkOutput("ird_s_wdata", s_wdata, 0);
    s_ready = 1; s_rdata = 32'h12345678;
    #1;
    checkOutput("ird_i_ready", i_ready, 1);
    checkOutput("ird_i_rdata", i_rdata, 32'h12345678);
    checkOutput("ird_d_ready", d_ready, 0);
    applyStimulus();
    s_ready = 0; i_valid = 0;

    // Reset in GNT_I aborts the access and restores I-first tie priority
    i_valid = 1; i_addr = 32'h80;
    applyStimulus();
    #1;
    checkOutput("rst_gnt_s_valid", s_valid, 1);
    rst = 1;
    applyStimulus();
    #1;
    checkOutput("rst_abort_s_valid", s_valid, 0);
    checkOutput("rst_abort_idle", idle, 1);
    checkOutput("rst_abort_i_ready", i_ready, 0);
    rst = 0; d_valid = 1; d_addr = 32'h900; d_wstrb = 0;
    applyStimulus();
    #1;
    checkOutput("rst_tie_first_addr", s_addr, 32'h80);
    s_ready = 1;
    #1;
    checkOutput("rst_tie_first_i_ready", i_ready, 1);
    applyStimulus();
    s_ready = 0; i_valid = 0;
    applyStimulus();
    #1;
    checkOutput("rst_tie_second_addr", s_addr, 32'h900);
    s_ready = 1;
    #1;
    checkOutput("rst_tie_second_d_ready", d_ready, 1);
    applyStimulus();
    s_ready = 0; d_valid = 0;
    applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l2_req_arbiter.md
# l2_req_arbiter

Two-master arbiter for native (valid/ready) memory requests. It sits directly upstream of the L2 cache in the external-memory subsystem, between the instruction-cache and data-cache back-ends and the single L2 front-end. It grants one transaction at a time using round-robin priority. It also serialises L2 force-invalidate requests so that an invalidate pulse never reaches the L2 while an access is outstanding.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of master and slave address ports
- DATA_W, 32, data width; wstrb width is DATA_W/8

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous and active-high
- i_valid  input  1  instruction master request, held until i_ready
- i_addr  input  ADDR_W  instruction address
- i_rdata  output  DATA_W  read data, equal to s_rdata
- i_ready  output  1  one-cycle transaction-complete pulse
- d_valid  input  1  data master request, held until d_ready
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  write data
- d_wstrb  input  DATA_W/8  byte strobes; 0 means read
- d_rdata  output  DATA_W  read data, equal to s_rdata
- d_ready  output  1  one-cycle transaction-complete pulse
- s_valid, s_addr, s_wdata, s_wstrb  output  1/ADDR_W/DATA_W/DATA_W/8  request to L2
- s_rdata  input  DATA_W  L2 read data
- s_ready  input  1  L2 completion pulse
- inv_req  input  1  invalidate request pulse, may arrive in any state
- force_inv  output  1  one-cycle invalidate strobe to L2
- idle  output  1  high in IDLE with no pending invalidate

## Operation
- FSM states: IDLE, GNT_I, GNT_D, INV.
- inv_pend flag:
  - Set by inv_req in any state.
  - Cleared on entry to INV.
  - Multiple inv_req pulses before service collapse into one invalidate.
- IDLE transitions, in priority order:
  - inv_pend set → INV.
  - Else exactly one of i_valid/d_valid set → GNT of that master.
  - Else both set → GNT of the master not granted last. The last_gnt register resets to D, so I wins the first tie.
  - Else stay in IDLE.
- GNT_x:
  - s_valid=1; s_addr, s_wdata and s_wstrb are muxed from master x.
  - The instruction master is read-only: s_wstrb=0 and s_wdata=0 in GNT_I.
  - On s_ready: x_ready=1 in the same cycle (combinational pass-through), last_gnt←x, next state IDLE.
  - inv_req arriving during GNT only sets inv_pend; it never aborts the transaction.
- INV: force_inv=1 for exactly one cycle, s_valid=0, next state IDLE. Requests waiting during INV are serviced afterwards.
- Outside GNT: s_valid=0 and s_addr/s_wdata/s_wstrb=0.
- The ready of the non-granted master is always 0. s_ready outside GNT is ignored and produces no master ready.
- i_rdata and d_rdata are wired to s_rdata unconditionally. They are meaningful only when the matching ready is high.
- Masters must not drop valid before ready. Behaviour when a master does so is undefined.

## Timing
- Reset (synchronous) sets: state=IDLE, inv_pend=0, last_gnt=D. All outputs read 0 except idle=1.
- Reset mid-transaction drops s_valid at the next edge. No ready is issued for the aborted access.
- Arbitration latency:
  - valid seen in IDLE at edge n → s_valid high in cycle n+1.
  - Minimum transaction length is 2 cycles: grant, then s_ready in the first GNT cycle.
- Back-to-back:
  - After ready, the arbiter spends one cycle in IDLE before the next grant.
  - Each master sees a gap of at least one cycle between its own ready pulses.
- Invalidate latency:
  - From IDLE: inv_req at edge n → force_inv high in cycle n+2 (set pending, then enter INV).
  - From GNT: force_inv follows completion by exactly 2 cycles (IDLE, then INV).
- Simultaneous inv_req and s_ready in GNT: the transaction completes and the invalidate is serviced next, before any new grant.

## Test plan
- Single D write: d_valid with addr=0x100, wdata=0xDEADBEEF, wstrb=0xF; L2 ready after 3 cycles → s_* carry exactly those values, d_ready pulses once, i_ready stays 0.
- Tie round-robin: i_valid and d_valid held from reset, L2 ready 1 cycle after each grant → grant order I, D, I, D; one IDLE cycle between grants.
- I read-only: i_valid with addr=0x40 → s_wstrb=0 and s_wdata=0; i_rdata equals s_rdata=0x12345678 on i_ready.
- Invalidate during access: inv_req pulsed twice while GNT_D is waiting; d_valid re-asserted → exactly one force_inv pulse, 2 cycles after d_ready, before the next grant.
- Reset mid-access: rst asserted in GNT_I → next cycle s_valid=0 and idle=1; a subsequent i/d tie grants I first.
- Spurious s_ready in IDLE or INV → no master ready asserted, state unchanged.
